// File: rtl/pry2oht_tree.sv
// Priority-to-one-hot converter built as a SPLIT-ary tree.
// Keeps only the highest-priority set bit of pry (lowest index for "LSB",
// highest index for "MSB") and reports whether any bit was set.
// The conversion is combinational; REGISTERED=1 adds one output flop stage.

// Flat base converter shared by the leaves and by every group-select level.
module pry2oht_base #(
  parameter int    N              = 4,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic [N-1:0] pry,
  output logic [N-1:0] oht,
  output logic         vld
);

  localparam bit MSB = (DIRECTION == "MSB");

  logic [N-1:0] x;
  logic [N-1:0] r;
  logic [N-1:0] p;
  logic         seen;

  function automatic logic [N-1:0] reverse(input logic [N-1:0] v);
    logic [N-1:0] o;
    for (int i = 0; i < N; i++) o[i] = v[N-1-i];
    return o;
  endfunction

  // MSB priority is handled by reversing into LSB order and back again;
  // reversal is pure wiring, so it does not disturb X tolerance.
  always_comb begin
    x    = pry;
    r    = '0;
    p    = '0;
    seen = 1'b0;
    if (MSB) x = reverse(pry);
    case (IMPLEMENTATION)
      0: begin
        // The running seen flag ANDs away every later bit, so X above the
        // first set bit can never reach oht or vld.
        for (int i = 0; i < N; i++) begin
          r[i] = x[i] & ~seen;
          seen = seen | x[i];
        end
      end
      1: begin
        // p[i] = OR of x[i-1:0], built by log-step doubling.
        p = x << 1;
        for (int s = 1; s < N; s = s * 2) p = p | (p << s);
        r    = x & ~p;
        seen = |x;
      end
      default: begin
        r    = x & (~x + N'(1));
        seen = |x;
      end
    endcase
    oht = MSB ? reverse(r) : r;
    vld = seen;
  end

endmodule

module pry2oht_tree #(
  parameter int    WIDTH          = 16,
  parameter int    SPLIT          = 4,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0,
  parameter bit    REGISTERED     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] oht,
  output logic             vld
);

  localparam int GW = WIDTH / SPLIT;

  logic [WIDTH-1:0] oht_p0;
  logic             vld_p0;
  logic             unused_clk_rst;

  assign unused_clk_rst = &{1'b0, clk, rst_n};

  if (WIDTH > SPLIT) begin : gen_tree
    logic [WIDTH-1:0] grp_oht;
    logic [SPLIT-1:0] grp_vld;
    logic [SPLIT-1:0] sel;

    for (genvar g = 0; g < SPLIT; g++) begin : gen_grp
      pry2oht_tree #(
        .WIDTH         (GW),
        .SPLIT         (SPLIT),
        .DIRECTION     (DIRECTION),
        .IMPLEMENTATION(IMPLEMENTATION),
        .REGISTERED    (1'b0)
      ) u_sub (
        .clk  (clk),
        .rst_n(rst_n),
        .pry  (pry[g*GW +: GW]),
        .oht  (grp_oht[g*GW +: GW]),
        .vld  (grp_vld[g])
      );
      // AND-mask, never mux: a deselected group may carry X in IMPLEMENTATION 0.
      assign oht_p0[g*GW +: GW] = grp_oht[g*GW +: GW] & {GW{sel[g]}};
    end

    // The group valids pick the winning group; its vld is the OR of all groups.
    pry2oht_base #(
      .N             (SPLIT),
      .DIRECTION     (DIRECTION),
      .IMPLEMENTATION(IMPLEMENTATION)
    ) u_sel (
      .pry(grp_vld),
      .oht(sel),
      .vld(vld_p0)
    );
  end else begin : gen_leaf
    pry2oht_base #(
      .N             (WIDTH),
      .DIRECTION     (DIRECTION),
      .IMPLEMENTATION(IMPLEMENTATION)
    ) u_leaf (
      .pry(pry),
      .oht(oht_p0),
      .vld(vld_p0)
    );
  end

  // ---- stage boundary: optional output register ----
  if (REGISTERED) begin : gen_reg
    logic [WIDTH-1:0] oht_p1;
    logic             vld_p1;

    // Capture the combinational result; reset clears the outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        oht_p1 <= '0;
        vld_p1 <= 1'b0;
      end else begin
        oht_p1 <= oht_p0;
        vld_p1 <= vld_p0;
      end
    end

    assign oht = oht_p1;
    assign vld = vld_p1;
  end else begin : gen_comb
    assign oht = oht_p0;
    assign vld = vld_p0;
  end

endmodule

// File: tb/tb_pry2oht_tree.sv
// Self-checking bench for pry2oht_tree: all three implementations side by
// side in both directions, plus a registered instance with async reset.
module tb_pry2oht_tree;

  logic        clk;
  logic        rst_n;
  logic [15:0] pry;
  logic [15:0] pry_r;

  logic [15:0] oht_l [3];
  logic        vld_l [3];
  logic [15:0] oht_m [3];
  logic        vld_m [3];
  logic [15:0] oht_r;
  logic        vld_r;

  logic [15:0] exp_lsb_q [$];
  logic [15:0] exp_msb_q [$];
  logic [15:0] exp_r_q   [$];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : gen_dut
    logic [15:0] ol;
    logic        vl;
    logic [15:0] om;
    logic        vm;
    pry2oht_tree #(.WIDTH(16), .SPLIT(4), .DIRECTION("LSB"), .IMPLEMENTATION(k), .REGISTERED(1'b0))
      u_lsb (.clk(clk), .rst_n(rst_n), .pry(pry), .oht(ol), .vld(vl));
    pry2oht_tree #(.WIDTH(16), .SPLIT(4), .DIRECTION("MSB"), .IMPLEMENTATION(k), .REGISTERED(1'b0))
      u_msb (.clk(clk), .rst_n(rst_n), .pry(pry), .oht(om), .vld(vm));
    assign oht_l[k] = ol;
    assign vld_l[k] = vl;
    assign oht_m[k] = om;
    assign vld_m[k] = vm;
  end

  pry2oht_tree #(.WIDTH(16), .SPLIT(4), .DIRECTION("LSB"), .IMPLEMENTATION(0), .REGISTERED(1'b1))
    u_reg (.clk(clk), .rst_n(rst_n), .pry(pry_r), .oht(oht_r), .vld(vld_r));

  // Reference: scan from the priority end and keep the first set bit.
  function automatic logic [15:0] ref_oht(input logic [15:0] p, input bit msb);
    logic [15:0] o;
    o = '0;
    if (!msb) begin
      for (int i = 0; i < 16; i++) if (p[i]) begin o[i] = 1'b1; return o; end
    end else begin
      for (int i = 15; i >= 0; i--) if (p[i]) begin o[i] = 1'b1; return o; end
    end
    return o;
  endfunction

  // Drive one combinational pattern and queue both direction expectations.
  task automatic drive_comb(input logic [15:0] v);
    pry = v;
    exp_lsb_q.push_back(ref_oht(v, 1'b0));
    exp_msb_q.push_back(ref_oht(v, 1'b1));
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pry_r = 16'h1234;
    #2;
    checks++;
    if (oht_r !== 16'h0000 || vld_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold oht=%h vld=%b expected oht=0000 vld=0", oht_r, vld_r);
    end
    @(posedge clk); #1;
    checks++;
    if (oht_r !== 16'h0000 || vld_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold_edge oht=%h vld=%b expected oht=0000 vld=0", oht_r, vld_r);
    end
  endtask

  task automatic test_idle;
    logic [15:0] e;
    drive_comb(16'h0000);
    e = exp_lsb_q.pop_front();
    void'(exp_msb_q.pop_front());
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oht_l[k] !== e || vld_l[k] !== 1'b0 || oht_m[k] !== e || vld_m[k] !== 1'b0) begin
        failures++;
        $display("FAIL idle imp%0d lsb=%h/%b msb=%h/%b expected 0000/0", k, oht_l[k], vld_l[k], oht_m[k], vld_m[k]);
      end
    end
  endtask

  task automatic test_walk;
    logic [15:0] el, em;
    for (int i = 0; i < 16; i++) begin
      drive_comb(16'h0001 << i);
      el = exp_lsb_q.pop_front();
      em = exp_msb_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (oht_l[k] !== el || vld_l[k] !== 1'b1 || oht_m[k] !== em || vld_m[k] !== 1'b1) begin
          failures++;
          $display("FAIL walk imp%0d bit=%0d lsb=%h/%b msb=%h/%b expected %h/1", k, i, oht_l[k], vld_l[k], oht_m[k], vld_m[k], el);
        end
      end
    end
  endtask

  task automatic test_x_tolerance;
    logic [15:0] v, e;
    for (int i = 0; i < 16; i++) begin
      v = '0;
      v[i] = 1'b1;
      for (int j = i + 1; j < 16; j++) v[j] = 1'bx;
      pry = v;
      e = 16'h0001 << i;
      exp_lsb_q.push_back(e);
      #1;
      e = exp_lsb_q.pop_front();
      checks++;
      if (oht_l[0] !== e || vld_l[0] !== 1'b1) begin
        failures++;
        $display("FAIL x_tol bit=%0d oht=%b vld=%b expected %b/1", i, oht_l[0], vld_l[0], e);
      end
    end
  endtask

  task automatic test_exhaustive;
    logic [15:0] el, em;
    for (int v = 1; v < 65536; v++) begin
      drive_comb(v[15:0]);
      el = exp_lsb_q.pop_front();
      em = exp_msb_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (oht_l[k] !== el || vld_l[k] !== 1'b1 || oht_m[k] !== em || vld_m[k] !== 1'b1) begin
          failures++;
          $display("FAIL exhaustive imp%0d pry=%h lsb=%h/%b msb=%h/%b expected %h/%h", k, v[15:0], oht_l[k], vld_l[k], oht_m[k], vld_m[k], el, em);
        end
      end
    end
  endtask

  task automatic test_examples;
    logic [15:0] pats [4];
    logic [15:0] lsb_e [4];
    logic [15:0] msb_e [4];
    logic [15:0] el, em;
    pats  = '{16'hFFFF, 16'hA0C0, 16'h0301, 16'h8001};
    lsb_e = '{16'h0001, 16'h0040, 16'h0001, 16'h0001};
    msb_e = '{16'h8000, 16'h8000, 16'h0200, 16'h8000};
    for (int n = 0; n < 4; n++) begin
      pry = pats[n];
      exp_lsb_q.push_back(lsb_e[n]);
      exp_msb_q.push_back(msb_e[n]);
      #1;
      el = exp_lsb_q.pop_front();
      em = exp_msb_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (oht_l[k] !== el || oht_m[k] !== em || vld_l[k] !== 1'b1 || vld_m[k] !== 1'b1) begin
          failures++;
          $display("FAIL example imp%0d pry=%h lsb=%h msb=%h expected %h %h", k, pats[n], oht_l[k], oht_m[k], el, em);
        end
      end
    end
  endtask

  task automatic test_registered;
    logic [15:0] e;
    @(negedge clk);
    rst_n = 1'b1;
    pry_r = 16'h0C00;
    exp_r_q.push_back(16'h0400);
    #1;
    checks++;
    if (oht_r !== 16'h0000 || vld_r !== 1'b0) begin
      failures++;
      $display("FAIL reg_before_edge oht=%h vld=%b expected 0000/0", oht_r, vld_r);
    end
    @(posedge clk); #1;
    e = exp_r_q.pop_front();
    checks++;
    if (oht_r !== e || vld_r !== 1'b1) begin
      failures++;
      $display("FAIL reg_first oht=%h vld=%b expected %h/1", oht_r, vld_r, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v, e;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      v = (n == 5) ? 16'h0000 : 16'($urandom_range(0, 65535));
      if (n == 39) v = 16'h0C00;
      pry_r = v;
      exp_r_q.push_back(ref_oht(v, 1'b0));
      @(posedge clk); #1;
      e = exp_r_q.pop_front();
      checks++;
      if (oht_r !== e || vld_r !== (v != 16'h0000)) begin
        failures++;
        $display("FAIL reg_stream n=%0d pry=%h oht=%h vld=%b expected %h", n, v, oht_r, vld_r, e);
      end
    end
  endtask

  task automatic test_midstream_reset;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (oht_r !== 16'h0000 || vld_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_async oht=%h vld=%b expected 0000/0", oht_r, vld_r);
    end
    @(posedge clk); #1;
    checks++;
    if (oht_r !== 16'h0000 || vld_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_held oht=%h vld=%b expected 0000/0", oht_r, vld_r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_r_q.push_back(16'h0400);
    @(posedge clk); #1;
    checks++;
    if (oht_r !== exp_r_q.pop_front() || vld_r !== 1'b1) begin
      failures++;
      $display("FAIL reset_recover oht=%h vld=%b expected 0400/1", oht_r, vld_r);
    end
  endtask

  initial begin
    pry   = '0;
    pry_r = '0;
    test_reset();
    test_idle();
    test_walk();
    test_x_tolerance();
    test_examples();
    test_exhaustive();
    test_registered();
    test_back_to_back();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
